// File: rtl/sn_to_bin_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoder.
// State encodings match the 2-bit SN2B_* values used across the dsc blocks.
package sn_to_bin_pkg;

  typedef enum logic [1:0] {
    SN2B_IDLE  = 2'd0,
    SN2B_COUNT = 2'd1,
    SN2B_DONE  = 2'd2
  } sn2b_state_e;

  function automatic int frame_len(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/sn_frame_ctr.sv
// Frame sample counter: WIDTH-bit up-counter with clear and enable.
// o_last flags the enabled cycle that takes the final sample of a frame.
module sn_frame_ctr
  import sn_to_bin_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_last
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(frame_len(WIDTH) - 1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = i_en && (r_cnt == LAST_IDX);

endmodule

// File: rtl/sn_to_bin.sv
// Stochastic-to-binary converter: counts ones of a unary bitstream over a
// frame of 2**WIDTH enabled samples and offers the total on valid/ready.
module sn_to_bin
  import sn_to_bin_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           en,
  input  logic           sn_in,
  output logic           busy,
  output logic [WIDTH:0] bin_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           start_err
);

  sn2b_state_e r_state, w_state_n;

  logic           w_clr;
  logic           w_sample;
  logic           w_last;
  logic           w_start_err;
  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH:0] r_acc;
  logic [WIDTH:0] r_bin;
  logic           r_busy;
  logic           r_valid;
  logic           r_start_err;

  function automatic logic [WIDTH:0] add_sample(input logic [WIDTH:0] acc, input logic bit_in);
    return acc + {{WIDTH{1'b0}}, bit_in};
  endfunction

  assign w_sample = (r_state == SN2B_COUNT) && en;

  sn_frame_ctr #(.WIDTH(WIDTH)) u_ctr (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_en   (w_sample),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_comb begin
    w_state_n   = r_state;
    w_clr       = 1'b0;
    w_start_err = 1'b0;
    case (r_state)
      SN2B_IDLE: begin
        if (start) begin
          w_state_n = SN2B_COUNT;
          w_clr     = 1'b1;
        end
      end
      SN2B_COUNT: begin
        w_start_err = start;
        if (w_last) w_state_n = SN2B_DONE;
      end
      SN2B_DONE: begin
        if (out_ready) begin
          // Accepting the result and a new start in one cycle chains frames.
          if (start) begin
            w_state_n = SN2B_COUNT;
            w_clr     = 1'b1;
          end else begin
            w_state_n = SN2B_IDLE;
          end
        end else begin
          w_start_err = start;
        end
      end
      default: w_state_n = SN2B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SN2B_IDLE;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_busy      <= (w_state_n == SN2B_COUNT);
      r_valid     <= (w_state_n == SN2B_DONE);
      r_start_err <= w_start_err;
    end
  end

  // The final sample is folded straight into the result so valid rises next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_bin <= '0;
    end else begin
      if (w_clr) begin
        r_acc <= '0;
      end else if (w_sample) begin
        r_acc <= add_sample(r_acc, sn_in);
      end
      if (w_sample && w_last) begin
        r_bin <= add_sample(r_acc, sn_in);
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign bin_out   = r_bin;
  assign start_err = r_start_err;

endmodule

// File: tb/tb_sn_to_bin.sv
// Directed bench for sn_to_bin: upstream generator modelled as sample k = (k < v),
// which yields exactly v ones per 16-sample frame.
module tb_sn_to_bin;

  localparam int WIDTH = 4;
  localparam int FLEN  = 1 << WIDTH;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           en = 1'b0;
  logic           sn_in = 1'b0;
  logic           out_ready = 1'b0;
  logic           busy;
  logic [WIDTH:0] bin_out;
  logic           out_valid;
  logic           start_err;

  int n_checks = 0;
  int n_fail   = 0;

  sn_to_bin #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en        (en),
    .sn_in     (sn_in),
    .busy      (busy),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    en    = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Drives samples first..last of a frame with value v; optional idle cycle before each.
  task automatic do_samples(input int v, input bit toggle, input int first, input int last,
                            output int cyc, output int busy_low);
    cyc = 0;
    busy_low = 0;
    for (int k = first; k <= last; k++) begin
      if (toggle) begin
        en    = 1'b0;
        sn_in = (k >= v);
        if (busy !== 1'b1) busy_low++;
        tick();
        cyc++;
      end
      en    = 1'b1;
      sn_in = (k < v);
      if (busy !== 1'b1) busy_low++;
      tick();
      cyc++;
    end
    en    = 1'b0;
    sn_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (bin_out !== 5'd0) begin n_fail++; $display("FAIL reset_bin got %0d want 0", bin_out); end
    n_checks++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", start_err); end
  endtask

  task automatic test_basic();
    int cyc, bl;
    out_ready = 1'b0;
    do_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got %b want 1", busy); end
    do_samples(11, 1'b0, 0, FLEN-2, cyc, bl);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early got %b want 0", out_valid); end
    do_samples(11, 1'b0, FLEN-1, FLEN-1, cyc, bl);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got %b want 0", busy); end
    n_checks++; if (bin_out !== 5'd11) begin n_fail++; $display("FAIL basic_bin got %0d want 11", bin_out); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_extremes();
    int cyc, bl;
    do_start();
    do_samples(16, 1'b0, 0, FLEN-1, cyc, bl);
    n_checks++; if (bin_out !== 5'b10000) begin n_fail++; $display("FAIL ones_bin got %b want 10000", bin_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_valid got %b want 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    do_start();
    do_samples(0, 1'b0, 0, FLEN-1, cyc, bl);
    n_checks++; if (bin_out !== 5'd0) begin n_fail++; $display("FAIL zeros_bin got %0d want 0", bin_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zeros_valid got %b want 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_en_toggle();
    int cyc, bl;
    do_start();
    do_samples(6, 1'b1, 0, FLEN-1, cyc, bl);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL toggle_len got %0d want 32", cyc); end
    n_checks++; if (bl !== 0) begin n_fail++; $display("FAIL toggle_busy got %0d low cycles want 0", bl); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL toggle_valid got %b want 1", out_valid); end
    n_checks++; if (bin_out !== 5'd6) begin n_fail++; $display("FAIL toggle_bin got %0d want 6", bin_out); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, bl;
    do_start();
    do_samples(9, 1'b0, 0, FLEN-1, cyc, bl);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      tick();
      start = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (bin_out !== 5'd9) begin n_fail++; $display("FAIL bp_bin[%0d] got %0d want 9", i, bin_out); end
      n_checks++;
      if (start_err !== (i == 1)) begin
        n_fail++; $display("FAIL bp_err[%0d] got %b want %b", i, start_err, (i == 1));
      end
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
    n_checks++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", start_err); end
    do_samples(3, 1'b0, 0, FLEN-1, cyc, bl);
    n_checks++; if (bin_out !== 5'd3) begin n_fail++; $display("FAIL b2b_bin got %0d want 3", bin_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2 got %b want 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc, bl;
    do_start();
    do_samples(12, 1'b0, 0, 8, cyc, bl);
    rst = 1'b1;
    en  = 1'b1;
    sn_in = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    sn_in = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_checks++; if (bin_out !== 5'd0) begin n_fail++; $display("FAIL rstmid_bin got %0d want 0", bin_out); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got %b want 0", busy); end
    do_start();
    do_samples(5, 1'b0, 0, FLEN-1, cyc, bl);
    n_checks++; if (bin_out !== 5'd5) begin n_fail++; $display("FAIL rstmid_bin2 got %0d want 5", bin_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid2 got %b want 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_start_mid();
    int cyc, bl;
    do_start();
    do_samples(7, 1'b0, 0, 3, cyc, bl);
    start = 1'b1;
    do_samples(7, 1'b0, 4, 4, cyc, bl);
    start = 1'b0;
    n_checks++; if (start_err !== 1'b1) begin n_fail++; $display("FAIL smid_err got %b want 1", start_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL smid_busy got %b want 1", busy); end
    do_samples(7, 1'b0, 5, 5, cyc, bl);
    n_checks++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL smid_err_pulse got %b want 0", start_err); end
    do_samples(7, 1'b0, 6, FLEN-1, cyc, bl);
    n_checks++; if (bin_out !== 5'd7) begin n_fail++; $display("FAIL smid_bin got %0d want 7", bin_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL smid_valid got %b want 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_en_toggle();
    test_back_to_back();
    test_reset_mid();
    test_start_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
